// File: rtl/rotary_register_editor.sv
// Bank of NUM_REGS encoder-editable registers with SELECT/EDIT modes and a host write port.
// Optional feature: define SATURATE_EN to clamp edits at 0 / all-ones instead of wrapping.
module rotary_register_editor #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2,
    parameter int STEP     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      right,
    input  logic                      left,
    input  logic                      down,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [IDX_W-1:0]          sel_idx,
    output logic [WIDTH-1:0]          sel_value,
    output logic                      edit_mode,
    output logic                      changed,
    output logic [NUM_REGS*WIDTH-1:0] regs_flat
);

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_EDIT   = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
    logic [WIDTH-1:0]   regs_q [NUM_REGS];
    logic [WIDTH-1:0]   regs_d [NUM_REGS];
    logic               changed_q, changed_d;

    logic               rot_r_s;
    logic               rot_l_s;
    logic [31:0]        wr_idx_ext_s;
    logic               wr_hit_s;
    logic               wr_same_s;
    logic [WIDTH-1:0]   cur_val_s;
    logic [WIDTH-1:0]   edit_val_s;
    logic               rot_edit_s;

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
`ifdef SATURATE_EN
        logic [WIDTH:0] sum;
        sum = {1'b0, v} + {1'b0, STEP_V};
        if (sum[WIDTH]) begin
            step_up = {WIDTH{1'b1}};
        end else begin
            step_up = sum[WIDTH-1:0];
        end
`else
        step_up = v + STEP_V;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
`ifdef SATURATE_EN
        if (v < STEP_V) begin
            step_down = {WIDTH{1'b0}};
        end else begin
            step_down = v - STEP_V;
        end
`else
        step_down = v - STEP_V;
`endif
    endfunction

    // A press always wins over rotation; opposing rotations cancel.
    assign rot_r_s      = right & ~left & ~down;
    assign rot_l_s      = left & ~right & ~down;
    assign wr_idx_ext_s = 32'(wr_idx);
    assign wr_hit_s     = wr_en & (wr_idx_ext_s < 32'(NUM_REGS));
    assign wr_same_s    = wr_hit_s & (wr_idx == sel_idx_q);
    assign cur_val_s    = regs_q[sel_idx_q];

    // Next-state, index, bank and change-pulse logic.
    always_comb begin
        state_d     = state_q;
        sel_idx_d   = sel_idx_q;
        regs_d      = regs_q;
        changed_d   = 1'b0;
        edit_val_s  = cur_val_s;
        rot_edit_s  = 1'b0;

        case (state_q)
            ST_SELECT: begin
                if (down) begin
                    state_d = ST_EDIT;
                end else if (rot_r_s) begin
                    sel_idx_d = (sel_idx_q == LAST_IDX) ? {IDX_W{1'b0}} : sel_idx_q + IDX_W'(1);
                end else if (rot_l_s) begin
                    sel_idx_d = (sel_idx_q == {IDX_W{1'b0}}) ? LAST_IDX : sel_idx_q - IDX_W'(1);
                end else begin
                    sel_idx_d = sel_idx_q;
                end
            end
            ST_EDIT: begin
                if (down) begin
                    state_d = ST_SELECT;
                end else if (rot_r_s) begin
                    edit_val_s = step_up(cur_val_s);
                end else if (rot_l_s) begin
                    edit_val_s = step_down(cur_val_s);
                end else begin
                    edit_val_s = cur_val_s;
                end
                rot_edit_s = (edit_val_s != cur_val_s);
            end
            default: begin
                state_d = ST_SELECT;
            end
        endcase

        // A host write to the register being edited drops the rotation step.
        if (rot_edit_s && !wr_same_s) begin
            regs_d[sel_idx_q] = edit_val_s;
            changed_d         = 1'b1;
        end else begin
            changed_d = 1'b0;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit_s && (wr_idx == IDX_W'(i))) begin
                regs_d[i] = wr_data;
            end else begin
                regs_d[i] = regs_d[i];
            end
        end
    end

    // State, index, bank and change-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SELECT;
            sel_idx_q <= {IDX_W{1'b0}};
            changed_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            changed_q <= changed_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
    end

    assign sel_idx   = sel_idx_q;
    assign sel_value = regs_q[sel_idx_q];
    assign edit_mode = (state_q == ST_EDIT);
    assign changed   = changed_q;

endmodule

// File: tb/tb_rotary_register_editor.sv
// Table-driven bench for rotary_register_editor (default parameters, wrap or SATURATE_EN build).
module tb_rotary_register_editor;

    logic        clk;
    logic        rst;
    logic        right;
    logic        left;
    logic        down;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [15:0] wr_data;
    logic [1:0]  sel_idx;
    logic [15:0] sel_value;
    logic        edit_mode;
    logic        changed;
    logic [63:0] regs_flat;

    int total;
    int bad;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic        r;
        logic        l;
        logic        d;
        logic        we;
        logic [1:0]  widx;
        logic [15:0] wdata;
        logic [1:0]  e_sel;
        logic        e_edit;
        logic        e_chg;
        logic [15:0] e_val;
        logic [63:0] e_flat;
    } vec_t;

    vec_t vecs[$];

    rotary_register_editor #(
        .WIDTH(16), .NUM_REGS(4), .IDX_W(2), .STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .right(right), .left(left), .down(down),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .sel_idx(sel_idx), .sel_value(sel_value), .edit_mode(edit_mode),
        .changed(changed), .regs_flat(regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] s, input logic e,
                             input logic c, input logic [15:0] v, input logic [63:0] f);
        check({tag, " sel_idx"}, 64'(sel_idx), 64'(s));
        check({tag, " edit_mode"}, 64'(edit_mode), 64'(e));
        check({tag, " changed"}, 64'(changed), 64'(c));
        check({tag, " sel_value"}, 64'(sel_value), 64'(v));
        check({tag, " regs_flat"}, regs_flat, f);
    endtask

    task automatic add(input logic r, input logic l, input logic d, input logic we,
                       input logic [1:0] widx, input logic [15:0] wdata,
                       input logic [1:0] s, input logic e, input logic c,
                       input logic [15:0] v, input logic [15:0] r0, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [15:0] r3);
        vec_t x;
        x.r = r; x.l = l; x.d = d; x.we = we; x.widx = widx; x.wdata = wdata;
        x.e_sel = s; x.e_edit = e; x.e_chg = c; x.e_val = v;
        x.e_flat = {r3, r2, r1, r0};
        vecs.push_back(x);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; right = 1'b0; left = 1'b0; down = 1'b0;
        wr_en = 1'b0; wr_idx = 2'd0; wr_data = 16'h0000;

        //   r     l     d     we    idx   data      sel   ed    chg   value     r0        r1        r2        r3
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd3, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd3, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b1, 16'h0003, 16'h0000, 16'h0000, 16'h0003, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd2, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0000);
        // host write collides with a rotation step on the same register: host wins
        add(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h1234, 2'd1, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1234, 16'h0002, 16'h0000);
        add(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 16'h00AA, 2'd1, 1'b1, 1'b1, 16'h1235, 16'h0000, 16'h1235, 16'h0002, 16'h00AA);
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0001, 2'd1, 1'b1, 1'b0, 16'h1235, 16'h0001, 16'h1235, 16'h0002, 16'h00AA);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd1, 1'b0, 1'b0, 16'h1235, 16'h0001, 16'h1235, 16'h0002, 16'h00AA);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h1235, 16'h0002, 16'h00AA);
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'h1235, 16'h0002, 16'h00AA);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h1235, 16'h0002, 16'h00AA);
        // lower boundary: wrap to all-ones, or clamp with no change pulse
        if (SAT) begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1235, 16'h0002, 16'h00AA);
            add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h0001, 16'h0001, 16'h1235, 16'h0002, 16'h00AA);
        end else begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h1235, 16'h0002, 16'h00AA);
            add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h1235, 16'h0002, 16'h00AA);
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'hFFFF, 2'd0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h1235, 16'h0002, 16'h00AA);
        // upper boundary
        if (SAT) begin
            add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h1235, 16'h0002, 16'h00AA);
        end else begin
            add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h1235, 16'h0002, 16'h00AA);
        end
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'h7777, 2'd0, 1'b1, 1'b0, SAT ? 16'hFFFF : 16'h0000,
            SAT ? 16'hFFFF : 16'h0000, 16'h1235, 16'h7777, 16'h00AA);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'd0, 1'b0, 1'b0, 16'h0000, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            right = vecs[i].r; left = vecs[i].l; down = vecs[i].d;
            wr_en = vecs[i].we; wr_idx = vecs[i].widx; wr_data = vecs[i].wdata;
            @(posedge clk);
            #1;
            right = 1'b0; left = 1'b0; down = 1'b0; wr_en = 1'b0;
            check_all($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_edit,
                      vecs[i].e_chg, vecs[i].e_val, vecs[i].e_flat);
        end

        // reset asserted mid-EDIT between clock edges
        check("pre-reset edit_mode", 64'(edit_mode), 64'(1'b1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all("async reset", 2'd0, 1'b0, 1'b0, 16'h0000, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("after release", 2'd0, 1'b0, 1'b0, 16'h0000, 64'h0);

        // bank still responds after reset: SELECT mode rotation
        @(negedge clk);
        right = 1'b1;
        @(posedge clk);
        #1;
        right = 1'b0;
        check_all("post-reset right", 2'd1, 1'b0, 1'b0, 16'h0000, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
